// File: rtl/bcd_encoder.sv
// Purpose : registered decimal (10-line) to BCD encoder with zero/multi-active flags
//           and a saturating error counter.
// Latency : one clock; every output is a register updated on the enabled rising edge.
// Backpr. : none; en=0 freezes all state, there is no handshake.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset, overrides en
//   en       - sample enable; low holds every register
//   D[9:0]   - decimal input lines, bit n means digit n
//   A[3:0]   - BCD code of the selected digit (0..9 only)
//   valid    - last sampled D had at least one active line
//   multi    - last sampled D had two or more active lines
//   err_cnt  - saturating count of sampled cycles with D==0 or multi-active
module bcd_encoder #(
  parameter int PRIORITY_HIGH = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [9:0]           D,
  output logic [3:0]           A,
  output logic                 valid,
  output logic                 multi,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [3:0] sel_idx;
  logic       any_act;
  logic       multi_act;
  logic       err_evt;
  logic       cnt_full;

  // Priority encode: the loop order makes the last matching index win, so
  // scanning upward favours the highest line and scanning downward the lowest.
  always_comb begin
    sel_idx = 4'd0;
    if (PRIORITY_HIGH != 0) begin
      for (int i = 0; i < 10; i++) begin
        if (D[i]) sel_idx = 4'(i);
      end
    end else begin
      for (int i = 9; i >= 0; i--) begin
        if (D[i]) sel_idx = 4'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any_act   = |D;
  assign multi_act = |(D & (D - 10'd1));
  assign err_evt   = ~any_act | multi_act;
  assign cnt_full  = &err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      A       <= 4'd0;
      valid   <= 1'b0;
      multi   <= 1'b0;
      err_cnt <= '0;
    end else if (en) begin
      // With no active line the last code is kept so downstream displays
      // do not flash a spurious 0.
      if (any_act) A <= sel_idx;
      valid <= any_act;
      multi <= multi_act;
      if (err_evt && !cnt_full) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bcd_encoder.sv
// Purpose : self-checking bench for bcd_encoder (high/low priority and 2-bit counter variants).
// Latency : inputs driven on the falling edge, outputs checked 1ns after the rising edge.
// Backpr. : not applicable; free-running directed stimulus.
module tb_bcd_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] D;

  logic [3:0] a_hi, a_lo, a_sat;
  logic       v_hi, v_lo, v_sat;
  logic       m_hi, m_lo, m_sat;
  logic [7:0] e_hi, e_lo;
  logic [1:0] e_sat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_encoder #(.PRIORITY_HIGH(1), .ERR_CNT_W(8)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .D(D),
    .A(a_hi), .valid(v_hi), .multi(m_hi), .err_cnt(e_hi));

  bcd_encoder #(.PRIORITY_HIGH(0), .ERR_CNT_W(8)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .D(D),
    .A(a_lo), .valid(v_lo), .multi(m_lo), .err_cnt(e_lo));

  bcd_encoder #(.PRIORITY_HIGH(1), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .D(D),
    .A(a_sat), .valid(v_sat), .multi(m_sat), .err_cnt(e_sat));

  typedef struct {
    logic       rst;
    logic       en;
    logic [9:0] d;
    int         a_hi;
    int         a_lo;
    int         valid;
    int         multi;
    int         err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [9:0] d,
                     input int ah, input int al, input int v, input int m, input int er);
    vec_t t;
    t.rst = r; t.en = e; t.d = d;
    t.a_hi = ah; t.a_lo = al; t.valid = v; t.multi = m; t.err = er;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, then observe just after the next rising edge.
  task automatic step(input logic r, input logic e, input logic [9:0] d);
    @(negedge clk);
    rst = r; en = e; D = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; D = '0;

    // Reset held two edges with all lines active.
    add(1, 1, 10'h3FF, 0, 0, 0, 0, 0);
    add(1, 1, 10'h3FF, 0, 0, 0, 0, 0);
    // One-hot walk.
    for (int m = 0; m < 10; m++) add(0, 1, 10'(1 << m), m, m, 1, 0, 0);
    // Zero input holds A, counts errors.
    add(0, 1, 10'h080, 7, 7, 1, 0, 0);
    add(0, 1, 10'h000, 7, 7, 0, 0, 1);
    add(0, 1, 10'h000, 7, 7, 0, 0, 2);
    add(0, 1, 10'h000, 7, 7, 0, 0, 3);
    // Multi-hot: lines 9 and 2.
    add(0, 1, 10'b10_0000_0100, 9, 2, 1, 1, 4);
    // Enable low: D walks, nothing moves.
    for (int m = 0; m < 10; m++) add(0, 0, 10'(1 << m), 9, 2, 1, 1, 4);
    add(0, 0, 10'h000, 9, 2, 1, 1, 4);
    // First enabled edge after hold.
    add(0, 1, 10'h010, 4, 4, 1, 0, 4);
    // All lines active: extremes of both priorities.
    add(0, 1, 10'h3FF, 9, 0, 1, 1, 5);
    // Adjacent pair in the middle.
    add(0, 1, 10'b00_0011_0000, 5, 4, 1, 1, 6);
    // Single line after multi clears multi, keeps count.
    add(0, 1, 10'h001, 0, 0, 1, 0, 6);
    // Reset wins over en=0.
    add(1, 0, 10'h3FF, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].d);
      chk($sformatf("v%0d A_hi", i), int'(a_hi), vecs[i].a_hi);
      chk($sformatf("v%0d A_lo", i), int'(a_lo), vecs[i].a_lo);
      chk($sformatf("v%0d valid", i), int'(v_hi), vecs[i].valid);
      chk($sformatf("v%0d multi", i), int'(m_hi), vecs[i].multi);
      chk($sformatf("v%0d multi_lo", i), int'(m_lo), vecs[i].multi);
      chk($sformatf("v%0d err_hi", i), int'(e_hi), vecs[i].err);
      chk($sformatf("v%0d err_lo", i), int'(e_lo), vecs[i].err);
    end

    // Mid-cycle D change must not leak before the next edge.
    step(0, 1, 10'h008);
    @(negedge clk);
    D = 10'h100;
    #2;
    chk("glitch A", int'(a_hi), 3);
    @(posedge clk); #1;
    chk("glitch A next", int'(a_hi), 8);

    // Saturation on the 2-bit counter: 1,2,3,3,3, never wraps.
    step(1, 1, 10'h000);
    chk("sat rst err", int'(e_sat), 0);
    step(0, 1, 10'h040);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 10'h000);
      chk($sformatf("sat err%0d", k), int'(e_sat), (k < 3) ? k : 3);
      chk($sformatf("sat A%0d", k), int'(a_sat), 6);
    end
    chk("sat err_hi", int'(e_hi), 5);
    step(0, 1, 10'h0C0);
    chk("sat multi err", int'(e_sat), 3);
    chk("sat multi A", int'(a_sat), 7);
    // Mid-run reset clears everything in one edge.
    step(1, 1, 10'h3FF);
    chk("mid rst A", int'(a_sat), 0);
    chk("mid rst valid", int'(v_sat), 0);
    chk("mid rst multi", int'(m_sat), 0);
    chk("mid rst err", int'(e_sat), 0);
    // First enabled edge after reset samples normally.
    step(0, 1, 10'h200);
    chk("post rst A", int'(a_sat), 9);
    chk("post rst valid", int'(v_sat), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
